cceip_apb_cfg_seq: RTL and testbench

CCEIP_APB_CFG_SEQ -- requirements
Module: cceip_apb_cfg_seq

---
 rtl/cceip_apb_cfg_seq.sv | 183 ++++++++++++++++++
 tb/tb_cceip_apb_cfg_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cceip_apb_cfg_seq.sv
// APB config sequencer: replays a table of writes/read-compares; 2N+1 cycles start->done for N zero-wait entries.
// Stalls in ACCESS while pready is low (aborts after TIMEOUT_CYC); tbl_we and start are ignored while busy.
module cceip_apb_cfg_seq #(
  parameter int NUM_ENTRIES = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             tbl_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   tbl_idx,
  input  logic                             tbl_op,
  input  logic [19:0]                      tbl_addr,
  input  logic [31:0]                      tbl_data,
  input  logic [$clog2(NUM_ENTRIES):0]     cfg_count,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       err,
  output logic [$clog2(NUM_ENTRIES)-1:0]   err_idx,
  output logic [19:0]                      m_apb_paddr,
  output logic                             m_apb_psel,
  output logic                             m_apb_penable,
  output logic                             m_apb_pwrite,
  output logic [31:0]                      m_apb_pwdata,
  input  logic [31:0]                      m_apb_prdata,
  input  logic                             m_apb_pready,
  input  logic                             m_apb_pslverr
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SLVERR  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_MISCMP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        err_q, err_d;
  logic [IDX_W-1:0]  err_idx_q, err_idx_d;

  logic              tbl_op_q   [NUM_ENTRIES];
  logic [19:0]       tbl_addr_q [NUM_ENTRIES];
  logic [31:0]       tbl_data_q [NUM_ENTRIES];
  logic              tbl_op_d   [NUM_ENTRIES];
  logic [19:0]       tbl_addr_d [NUM_ENTRIES];
  logic [31:0]       tbl_data_d [NUM_ENTRIES];

  logic              cur_op;
  logic [19:0]       cur_addr;
  logic [31:0]       cur_data;
  logic [CNT_W-1:0]  cnt_clamp;
  logic              last_entry;
  logic              xfer_act;

  assign cur_op     = tbl_op_q[idx_q];
  assign cur_addr   = tbl_addr_q[idx_q];
  assign cur_data   = tbl_data_q[idx_q];
  assign cnt_clamp  = (cfg_count > CNT_W'(NUM_ENTRIES)) ? CNT_W'(NUM_ENTRIES) : cfg_count;
  assign last_entry = (({1'b0, idx_q} + CNT_W'(1)) == cnt_q);
  assign xfer_act   = (state_q == SETUP) || (state_q == ACCESS);

  // Table is only writable between sequences so a running sequence sees a stable program.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      tbl_op_d[i]   = tbl_op_q[i];
      tbl_addr_d[i] = tbl_addr_q[i];
      tbl_data_d[i] = tbl_data_q[i];
    end
    if (tbl_we && (state_q == IDLE)) begin
      tbl_op_d[tbl_idx]   = tbl_op;
      tbl_addr_d[tbl_idx] = tbl_addr;
      tbl_data_d[tbl_idx] = tbl_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d     = ERR_OK;
          err_idx_d = '0;
          idx_d     = '0;
          cnt_d     = cnt_clamp;
          state_d   = (cnt_clamp == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        tmo_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (m_apb_pready) begin
          // Slave error outranks a data miscompare on the same beat.
          if (m_apb_pslverr) begin
            err_d     = ERR_SLVERR;
            err_idx_d = idx_q;
            state_d   = DONE;
          end else if (cur_op && (m_apb_prdata != cur_data)) begin
            err_d     = ERR_MISCMP;
            err_idx_d = idx_q;
            state_d   = DONE;
          end else if (last_entry) begin
            state_d   = DONE;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            state_d   = SETUP;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_d     = ERR_TIMEOUT;
          err_idx_d = idx_q;
          state_d   = DONE;
        end else begin
          tmo_d     = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      err_idx_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_op_q[i]   <= 1'b0;
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_op_q[i]   <= tbl_op_d[i];
        tbl_addr_q[i] <= tbl_addr_d[i];
        tbl_data_q[i] <= tbl_data_d[i];
      end
    end
  end

  // APB outputs decode straight from state so reset forces them low without waiting for a clock.
  assign m_apb_psel    = xfer_act;
  assign m_apb_penable = (state_q == ACCESS);
  assign m_apb_pwrite  = xfer_act && !cur_op;
  assign m_apb_paddr   = xfer_act ? cur_addr : 20'h0;
  assign m_apb_pwdata  = (xfer_act && !cur_op) ? cur_data : 32'h0;

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_cceip_apb_cfg_seq.sv
// Directed bench for cceip_apb_cfg_seq: APB slave stub, transfer monitor, hand-computed expectations.
module tb_cceip_apb_cfg_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        tbl_we;
  logic [3:0]  tbl_idx;
  logic        tbl_op;
  logic [19:0] tbl_addr;
  logic [31:0] tbl_data;
  logic [4:0]  cfg_count;
  logic        start;
  logic        busy, done;
  logic [1:0]  err;
  logic [3:0]  err_idx;
  logic [19:0] m_apb_paddr;
  logic        m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [31:0] m_apb_pwdata;
  logic [31:0] m_apb_prdata;
  logic        m_apb_pready, m_apb_pslverr;

  logic        slv_rdy, slv_err, stall_en;
  logic [19:0] stall_addr;
  logic [31:0] slv_rdata;

  int n_vec = 0;
  int n_mis = 0;
  int acc_tot = 0;
  int setup_tot = 0;
  logic [52:0] mon_q[$];

  always #5 ap_clk = ~ap_clk;

  assign m_apb_pready  = slv_rdy && !(stall_en && (m_apb_paddr == stall_addr));
  assign m_apb_pslverr = slv_err;
  assign m_apb_prdata  = slv_rdata;

  cceip_apb_cfg_seq #(.NUM_ENTRIES(16), .TIMEOUT_CYC(256)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_op(tbl_op), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cfg_count(cfg_count), .start(start),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .m_apb_paddr(m_apb_paddr), .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable),
    .m_apb_pwrite(m_apb_pwrite), .m_apb_pwdata(m_apb_pwdata),
    .m_apb_prdata(m_apb_prdata), .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr)
  );

  always @(negedge ap_clk) begin
    if (m_apb_psel && m_apb_penable && m_apb_pready)
      mon_q.push_back({m_apb_pwrite, m_apb_paddr, m_apb_pwdata});
    if (m_apb_psel && m_apb_penable) acc_tot++;
    if (m_apb_psel && !m_apb_penable) setup_tot++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] idx, input logic op, input logic [19:0] a, input logic [31:0] d);
    tbl_we = 1'b1; tbl_idx = idx; tbl_op = op; tbl_addr = a; tbl_data = d;
    @(negedge ap_clk);
    tbl_we = 1'b0;
  endtask

  // Pulses start at a negedge; returns the cycle number (start cycle = 0) in which done is seen.
  task automatic run(input logic [4:0] cnt, input int max_cyc, output int lat);
    cfg_count = cnt;
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < max_cyc) begin
      @(negedge ap_clk);
      lat++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic wait_acc(input logic [19:0] a);
    int k = 0;
    while (!(m_apb_psel && m_apb_penable && m_apb_paddr == a) && k < 40) begin
      @(negedge ap_clk);
      k++;
    end
    chk("wait_access", (k < 40), 1'b1);
  endtask

  task automatic chk_idle_after(input string tag);
    @(negedge ap_clk);
    chk({tag, "_done_1cyc"}, done, 1'b0);
    chk({tag, "_busy_clr"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat, base, abase, sbase;
    ap_rst_n = 1'b1; tbl_we = 0; tbl_idx = 0; tbl_op = 0; tbl_addr = 0; tbl_data = 0;
    cfg_count = 0; start = 0; slv_rdy = 1; slv_err = 0; stall_en = 0; stall_addr = 0; slv_rdata = 0;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_apb", {m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr, m_apb_pwdata}, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Three zero-wait writes
    load(0, 0, 20'h00100, 32'hA5A5A5A5);
    load(1, 0, 20'h00104, 32'h1);
    load(2, 0, 20'h00108, 32'h2);
    base = mon_q.size(); abase = acc_tot; sbase = setup_tot;
    run(3, 50, lat);
    chk("wr3_latency", lat, 7);
    chk("wr3_err", err, 0);
    chk("wr3_nxfer", mon_q.size() - base, 3);
    chk("wr3_x0", mon_q[base],   {1'b1, 20'h00100, 32'hA5A5A5A5});
    chk("wr3_x1", mon_q[base+1], {1'b1, 20'h00104, 32'h1});
    chk("wr3_x2", mon_q[base+2], {1'b1, 20'h00108, 32'h2});
    chk("wr3_setup_cyc", setup_tot - sbase, 3);
    chk("wr3_access_cyc", acc_tot - abase, 3);
    chk_idle_after("wr3");

    // Read-compare mismatch on entry 1
    load(0, 0, 20'h00200, 32'h11);
    load(1, 1, 20'h00204, 32'h12345678);
    load(2, 0, 20'h00208, 32'h22);
    slv_rdata = 32'h12345679;
    base = mon_q.size();
    run(3, 50, lat);
    chk("miscmp_latency", lat, 5);
    chk("miscmp_err", err, 2'b11);
    chk("miscmp_err_idx", err_idx, 1);
    chk("miscmp_nxfer", mon_q.size() - base, 2);
    chk("miscmp_rd_xfer", mon_q[base+1], {1'b0, 20'h00204, 32'h0});
    chk_idle_after("miscmp");

    // Timeout on entry 0
    load(0, 0, 20'h00300, 32'h33);
    stall_addr = 20'h00300; stall_en = 1'b1;
    abase = acc_tot;
    run(1, 400, lat);
    chk("tmo_latency", lat, 258);
    chk("tmo_access_cyc", acc_tot - abase, 256);
    chk("tmo_err", err, 2'b10);
    chk("tmo_err_idx", err_idx, 0);
    chk("tmo_psel_drop", {m_apb_psel, m_apb_penable}, 0);
    stall_en = 1'b0;
    chk_idle_after("tmo");

    // pslverr wins over a simultaneous miscompare
    load(0, 1, 20'h00400, 32'hCAFEF00D);
    slv_rdata = 32'h0; slv_err = 1'b1;
    run(1, 50, lat);
    chk("slverr_latency", lat, 3);
    chk("slverr_err", err, 2'b01);
    chk("slverr_err_idx", err_idx, 0);
    slv_err = 1'b0;
    chk_idle_after("slverr");

    // Zero count: straight to done, err cleared, no bus activity
    base = mon_q.size(); sbase = setup_tot;
    run(0, 10, lat);
    chk("cnt0_latency", lat, 1);
    chk("cnt0_err", err, 0);
    chk("cnt0_nxfer", mon_q.size() - base, 0);
    chk("cnt0_setup", setup_tot - sbase, 0);
    chk_idle_after("cnt0");

    // Count larger than the table is clamped to 16 entries
    for (int i = 0; i < 16; i++) load(4'(i), 0, 20'h00500 + 20'(4*i), 32'(3*i + 1));
    base = mon_q.size();
    run(5'd31, 100, lat);
    chk("clamp_latency", lat, 33);
    chk("clamp_nxfer", mon_q.size() - base, 16);
    chk("clamp_last", mon_q[base+15], {1'b1, 20'h0053C, 32'd46});
    chk("clamp_err", err, 0);
    chk_idle_after("clamp");

    // tbl_we and start while busy are ignored
    load(0, 0, 20'h00600, 32'h61);
    load(1, 0, 20'h00604, 32'h62);
    load(2, 0, 20'h00608, 32'h63);
    stall_addr = 20'h00608; stall_en = 1'b1;
    base = mon_q.size();
    cfg_count = 3; start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    wait_acc(20'h00608);
    tbl_we = 1'b1; tbl_idx = 0; tbl_op = 1; tbl_addr = 20'h007FF; tbl_data = 32'hDEAD; cfg_count = 1; start = 1'b1;
    @(negedge ap_clk);
    tbl_we = 1'b0; start = 1'b0;
    chk("busy_hold", busy, 1);
    stall_en = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge ap_clk); lat++; end
    chk("busy_done_seen", done, 1);
    chk("busy_nxfer", mon_q.size() - base, 3);
    repeat (2) @(negedge ap_clk);
    chk("busy_start_ignored", busy, 0);
    base = mon_q.size();
    run(1, 20, lat);
    chk("busy_tbl_unchanged", mon_q[base], {1'b1, 20'h00600, 32'h61});
    chk_idle_after("busy");

    // Asynchronous reset during ACCESS of entry 2
    stall_en = 1'b1;
    cfg_count = 3; start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    wait_acc(20'h00608);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst_psel", {m_apb_psel, m_apb_penable}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_paddr", m_apb_paddr, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1; stall_en = 1'b0;
    base = mon_q.size();
    run(1, 20, lat);
    chk("arst_first_start_lat", lat, 3);
    chk("arst_tbl_cleared", mon_q[base], {1'b1, 20'h0, 32'h0});
    chk_idle_after("arst");
    load(0, 0, 20'h00100, 32'hA5A5A5A5);
    load(1, 0, 20'h00104, 32'h1);
    load(2, 0, 20'h00108, 32'h2);
    base = mon_q.size();
    run(3, 50, lat);
    chk("arst_rerun_latency", lat, 7);
    chk("arst_rerun_err", err, 0);
    chk("arst_rerun_nxfer", mon_q.size() - base, 3);
    chk("arst_rerun_x2", mon_q[base+2], {1'b1, 20'h00108, 32'h2});
    chk_idle_after("arst_rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
